// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: valid/ready word load, one bit per clock,
// frame strobe while bits are valid, done on the last bit, gap-free streaming.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             frame,
  output logic             done,
  output logic             busy
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             serial_q, serial_d;
  logic             frame_q, frame_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             lastBit;
  logic             accept;

  // A new word may enter in IDLE or on the last-bit cycle, which is what
  // makes back-to-back words seamless.
  assign lastBit    = (state_q == SHIFT) && (cnt_q == LAST);
  assign load_ready = (state_q == IDLE) || lastBit;
  assign accept     = load_valid && load_ready;

  function automatic logic [WIDTH-1:0] shiftOne(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) return {v[WIDTH-2:0], 1'b0};
    else           return {1'b0, v[WIDTH-1:1]};
  endfunction

  function automatic logic firstBit(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) return v[WIDTH-1];
    else           return v[0];
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      serial_q <= 1'b0;
      frame_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      serial_q <= serial_d;
      frame_q  <= frame_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = data_in;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (accept) begin
          shreg_d = data_in;
          cnt_d   = '0;
        end else if (lastBit) begin
          state_d = IDLE;
          shreg_d = shiftOne(shreg_q);
          cnt_d   = '0;
        end else begin
          shreg_d = shiftOne(shreg_q);
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are decoded from next state and registered, so they line up with
  // the shift register contents without any path from the inputs.
  always_comb begin
    busy_d   = (state_d == SHIFT);
    frame_d  = busy_d;
    serial_d = busy_d && firstBit(shreg_d);
    done_d   = busy_d && (cnt_d == LAST);
  end

  assign serial_out = serial_q;
  assign frame      = frame_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: three instances (8-bit MSB-first,
// 8-bit LSB-first, 2-bit MSB-first) each checked bit-by-bit against a queue.
module tb_piso_serializer;

  typedef struct packed {
    logic sbit;
    logic last;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] dataA = '0;
  logic [7:0] dataB = '0;
  logic [1:0] dataC = '0;
  logic       validA = 1'b0;
  logic       validB = 1'b0;
  logic       validC = 1'b0;
  logic       readyA, readyB, readyC;
  logic       sA, sB, sC;
  logic       fA, fB, fC;
  logic       dnA, dnB, dnC;
  logic       bA, bB, bC;

  exp_t qA[$];
  exp_t qB[$];
  exp_t qC[$];
  int   nVec = 0;
  int   nMis = 0;
  bit   monEn = 1'b0;

  always #5 clock = ~clock;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dutA (
    .clock(clock), .reset(reset), .data_in(dataA), .load_valid(validA),
    .load_ready(readyA), .serial_out(sA), .frame(fA), .done(dnA), .busy(bA)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dutB (
    .clock(clock), .reset(reset), .data_in(dataB), .load_valid(validB),
    .load_ready(readyB), .serial_out(sB), .frame(fB), .done(dnB), .busy(bB)
  );

  piso_serializer #(.WIDTH(2), .MSB_FIRST(1'b1)) dutC (
    .clock(clock), .reset(reset), .data_in(dataC), .load_valid(validC),
    .load_ready(readyC), .serial_out(sC), .frame(fC), .done(dnC), .busy(bC)
  );

  task automatic compare(input string nm, input logic [31:0] act, input logic [31:0] req);
    nVec++;
    if (act !== req) begin
      nMis++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Queue the bits a word must produce, in transmission order.
  task automatic expectWord(input int id, input logic [31:0] word, input int width, input bit msbFirst);
    exp_t e;
    for (int k = 0; k < width; k++) begin
      e.sbit = msbFirst ? word[width-1-k] : word[k];
      e.last = (k == width - 1);
      case (id)
        0:       qA.push_back(e);
        1:       qB.push_back(e);
        default: qC.push_back(e);
      endcase
    end
  endtask

  task automatic applyStimulus(input int id, input logic [7:0] word, input logic valid);
    case (id)
      0: begin dataA = word;      validA = valid; end
      1: begin dataB = word;      validB = valid; end
      default: begin dataC = word[1:0]; validC = valid; end
    endcase
  endtask

  task automatic checkOutput(input string nm, input int id, input logic fr,
                             input logic so, input logic dn, input logic bz);
    exp_t e;
    int   qsize;
    case (id)
      0:       qsize = qA.size();
      1:       qsize = qB.size();
      default: qsize = qC.size();
    endcase
    if (fr) begin
      if (qsize == 0) begin
        compare({nm, ".unexpected_frame"}, 32'(fr), 32'd0);
      end else begin
        case (id)
          0:       e = qA.pop_front();
          1:       e = qB.pop_front();
          default: e = qC.pop_front();
        endcase
        compare({nm, ".serial_out"}, 32'(so), 32'(e.sbit));
        compare({nm, ".done"}, 32'(dn), 32'(e.last));
        compare({nm, ".busy"}, 32'(bz), 32'd1);
      end
    end else begin
      compare({nm, ".frame_gap"}, 32'(qsize), 32'd0);
      compare({nm, ".idle_serial"}, 32'(so), 32'd0);
      compare({nm, ".idle_done"}, 32'(dn), 32'd0);
      compare({nm, ".idle_busy"}, 32'(bz), 32'd0);
    end
  endtask

  // Monitor samples mid-cycle, away from the rising edge.
  always @(negedge clock) begin
    if (monEn) begin
      checkOutput("A", 0, fA, sA, dnA, bA);
      checkOutput("B", 1, fB, sB, dnB, bB);
      checkOutput("C", 2, fC, sC, dnC, bC);
    end
  end

  initial begin
    // Reset state
    reset = 1'b1;
    tick(2);
    monEn = 1'b1;
    tick(1);
    reset = 1'b0;
    compare("A.ready_after_reset", 32'(readyA), 32'd1);
    compare("B.ready_after_reset", 32'(readyB), 32'd1);
    compare("C.ready_after_reset", 32'(readyC), 32'd1);
    tick(1);

    // Single word A5, MSB first
    applyStimulus(0, 8'hA5, 1'b1);
    tick(1);
    expectWord(0, 32'hA5, 8, 1'b1);
    applyStimulus(0, 8'h00, 1'b0);
    tick(10);

    // LSB first: 01 then B4 back-to-back
    applyStimulus(1, 8'h01, 1'b1);
    tick(1);
    expectWord(1, 32'h01, 8, 1'b0);
    applyStimulus(1, 8'hB4, 1'b1);
    tick(2);
    compare("B.ready_midword", 32'(readyB), 32'd0);
    tick(5);
    compare("B.ready_lastbit", 32'(readyB), 32'd1);
    tick(1);
    expectWord(1, 32'hB4, 8, 1'b0);
    applyStimulus(1, 8'h00, 1'b0);
    tick(10);

    // Back-to-back A5 then 3C with valid held
    applyStimulus(0, 8'hA5, 1'b1);
    tick(1);
    expectWord(0, 32'hA5, 8, 1'b1);
    applyStimulus(0, 8'h3C, 1'b1);
    tick(7);
    compare("A.ready_lastbit_b2b", 32'(readyA), 32'd1);
    tick(1);
    expectWord(0, 32'h3C, 8, 1'b1);
    applyStimulus(0, 8'h00, 1'b0);
    tick(10);

    // Mid-word load attempt is ignored until the last-bit cycle
    applyStimulus(0, 8'hA5, 1'b1);
    tick(1);
    expectWord(0, 32'hA5, 8, 1'b1);
    applyStimulus(0, 8'h00, 1'b0);
    tick(3);
    applyStimulus(0, 8'hFF, 1'b1);
    compare("A.ready_bit3", 32'(readyA), 32'd0);
    tick(4);
    compare("A.ready_bit7", 32'(readyA), 32'd1);
    tick(1);
    expectWord(0, 32'hFF, 8, 1'b1);
    applyStimulus(0, 8'h00, 1'b0);
    tick(10);

    // Reset during bit 4 with a competing load
    applyStimulus(0, 8'hA5, 1'b1);
    tick(1);
    expectWord(0, 32'hA5, 8, 1'b1);
    applyStimulus(0, 8'h00, 1'b0);
    tick(4);
    reset = 1'b1;
    applyStimulus(0, 8'hFF, 1'b1);
    tick(1);
    qA.delete();
    reset = 1'b0;
    applyStimulus(0, 8'h00, 1'b0);
    compare("A.reset_serial", 32'(sA), 32'd0);
    compare("A.reset_frame", 32'(fA), 32'd0);
    compare("A.reset_done", 32'(dnA), 32'd0);
    compare("A.reset_busy", 32'(bA), 32'd0);
    compare("A.reset_ready", 32'(readyA), 32'd1);
    tick(4);

    // WIDTH=2 stream 10 then 01
    applyStimulus(2, 8'h02, 1'b1);
    compare("C.ready_c0", 32'(readyC), 32'd1);
    tick(1);
    expectWord(2, 32'h2, 2, 1'b1);
    applyStimulus(2, 8'h01, 1'b1);
    compare("C.ready_c1", 32'(readyC), 32'd0);
    tick(1);
    compare("C.ready_c2", 32'(readyC), 32'd1);
    tick(1);
    expectWord(2, 32'h1, 2, 1'b1);
    applyStimulus(2, 8'h00, 1'b0);
    tick(1);
    compare("C.ready_c4", 32'(readyC), 32'd1);
    tick(4);

    monEn = 1'b0;
    compare("A.queue_drained", 32'(qA.size()), 32'd0);
    compare("B.queue_drained", 32'(qB.size()), 32'd0);
    compare("C.queue_drained", 32'(qC.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
